load_store_unit: RTL and testbench

Data-side load/store unit: the responder to the decoder's LSU request (`req_data_o`/`we_data_o`). It accepts one memory operation at a time from decode/ALU, drives the data-memory bus with a req/gnt/rvalid handshake, aligns byte lanes for stores, and extracts and sign- or zero-extends load data for register writeback. It sits between the execute stage and the data memory port.

---
 rtl/load_store_unit_pkg.sv | 35 +++
 rtl/lsu_data_align.sv | 35 +++
 rtl/load_store_unit.sv | 226 ++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types and helpers for the load/store unit
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      LSU_WORD = 2'b00,
      LSU_HALF = 2'b01,
      LSU_BYTE = 2'b10
   } lsu_type;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GNT1    = 3'd1,
      RVALID1 = 3'd2,
      GNT2    = 3'd3,
      RVALID2 = 3'd4
   } lsu_state;

   // Encoding 11 is illegal and behaves as a word access
   function automatic lsu_type decode_type(input logic [1:0] raw);
      case (raw)
         2'b01:   return LSU_HALF;
         2'b10:   return LSU_BYTE;
         default: return LSU_WORD;
      endcase
   endfunction

   function automatic logic [7:0] lane_mask(input lsu_type t);
      case (t)
         LSU_HALF: return 8'h03;
         LSU_BYTE: return 8'h01;
         default:  return 8'h0F;
      endcase
   endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - byte-lane enables, store rotation and load extraction
module lsu_data_align
   import load_store_unit_pkg::*;
(
   input  logic [1:0]  acc_type,
   input  logic [1:0]  off,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [7:0]  be_full,
   output logic [31:0] wdata_rot,
   output logic [31:0] load_data
);

   lsu_type    t;
   logic [4:0] sh;
   logic [5:0] sh_inv;
   logic [31:0] rrot;

   always_comb begin
      t         = decode_type(acc_type);
      sh        = {off, 3'b000};
      sh_inv    = 6'd32 - {1'b0, sh};
      // Upper nibble of be_full holds the lanes that spill into the next word
      be_full   = lane_mask(t) << off;
      wdata_rot = (wdata << sh) | (wdata >> sh_inv);
      rrot      = (rdata >> sh) | (rdata << sh_inv);
      case (t)
         LSU_BYTE: load_data = {{24{sign_ext & rrot[7]}}, rrot[7:0]};
         LSU_HALF: load_data = {{16{sign_ext & rrot[15]}}, rrot[15:0]};
         default:  load_data = rrot;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-side LSU with req/gnt/rvalid bus and timeout
// Optional split of misaligned accesses: define LSU_MISALIGNED_EN.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [1:0]  lsu_type_i,
   input  logic        lsu_sign_ext_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_wdata_i,
   output logic        lsu_ready_o,
   output logic        lsu_done_o,
   output logic        lsu_rdata_valid_o,
   output logic [31:0] lsu_rdata_o,
   output logic        lsu_err_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic        data_err_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i
);

   lsu_state    state_q, state_d;
   logic [1:0]  cap_type_q, cap_off_q;
   logic        cap_we_q, cap_sign_q;
   logic [31:0] tmo_cnt_q;
   logic        tmo_hit, accept, reject_mis;
   logic [1:0]  sel_type, sel_off;
   logic [7:0]  be_full;
   logic [31:0] wdata_rot, load_word, load_data;
   logic        ready_d, req_d, we_d, done_d, err_d, rvalid_d;
   logic [3:0]  be_d;
   logic [31:0] addr_d, wdata_d, rdata_d;
`ifdef LSU_MISALIGNED_EN
   logic [3:0]  cap_be_hi_q;
   logic [31:0] beat1_q;
`endif

   // While idle the aligner sees the incoming request, otherwise the captured one
   assign sel_type = (state_q == IDLE) ? lsu_type_i : cap_type_q;
   assign sel_off  = (state_q == IDLE) ? lsu_addr_i[1:0] : cap_off_q;
   assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == 32'(TIMEOUT_CYCLES));

`ifdef LSU_MISALIGNED_EN
   assign reject_mis = 1'b0;
   always_comb begin
      load_word = data_rdata_i;
      if (state_q == RVALID2) begin
         for (int i = 0; i < 4; i++)
            if (!data_be_o[i]) load_word[8*i +: 8] = beat1_q[8*i +: 8];
      end
   end
`else
   assign reject_mis = |be_full[7:4];
   assign load_word  = data_rdata_i;
`endif

   lsu_data_align u_align (
      .acc_type  (sel_type),
      .off       (sel_off),
      .sign_ext  (cap_sign_q),
      .wdata     (lsu_wdata_i),
      .rdata     (load_word),
      .be_full   (be_full),
      .wdata_rot (wdata_rot),
      .load_data (load_data)
   );

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rvalid_d = 1'b0;
      rdata_d  = lsu_rdata_o;
      addr_d   = data_addr_o;
      be_d     = data_be_o;
      wdata_d  = data_wdata_o;
      we_d     = data_we_o;
      case (state_q)
         IDLE: begin
            if (lsu_req_i) begin
               accept = 1'b1;
               if (reject_mis) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  state_d = GNT1;
                  addr_d  = {lsu_addr_i[31:2], 2'b00};
                  be_d    = be_full[3:0];
                  wdata_d = wdata_rot;
                  we_d    = lsu_we_i;
               end
            end
         end
         GNT1: begin
            if (tmo_hit) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (data_gnt_i) begin
               state_d = RVALID1;
            end
         end
         RVALID1: begin
            if (tmo_hit) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (data_rvalid_i) begin
               if (data_err_i) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end
`ifdef LSU_MISALIGNED_EN
               else if (|cap_be_hi_q) begin
                  state_d = GNT2;
                  addr_d  = data_addr_o + 32'd4;
                  be_d    = cap_be_hi_q;
               end
`endif
               else begin
                  state_d  = IDLE;
                  done_d   = 1'b1;
                  rvalid_d = !cap_we_q;
                  if (!cap_we_q) rdata_d = load_data;
               end
            end
         end
`ifdef LSU_MISALIGNED_EN
         GNT2: begin
            if (tmo_hit) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (data_gnt_i) begin
               state_d = RVALID2;
            end
         end
         RVALID2: begin
            if (tmo_hit) begin
               state_d = IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end else if (data_rvalid_i) begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (data_err_i) begin
                  err_d = 1'b1;
               end else if (!cap_we_q) begin
                  rvalid_d = 1'b1;
                  rdata_d  = load_data;
               end
            end
         end
`endif
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      req_d   = (state_d == GNT1) || (state_d == GNT2);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q           <= IDLE;
         lsu_ready_o       <= 1'b1;
         lsu_done_o        <= 1'b0;
         lsu_rdata_valid_o <= 1'b0;
         lsu_err_o         <= 1'b0;
         lsu_rdata_o       <= '0;
         data_req_o        <= 1'b0;
         data_we_o         <= 1'b0;
         data_be_o         <= '0;
         data_addr_o       <= '0;
         data_wdata_o      <= '0;
         tmo_cnt_q         <= '0;
         cap_type_q        <= '0;
         cap_off_q         <= '0;
         cap_we_q          <= 1'b0;
         cap_sign_q        <= 1'b0;
`ifdef LSU_MISALIGNED_EN
         cap_be_hi_q       <= '0;
         beat1_q           <= '0;
`endif
      end else begin
         state_q           <= state_d;
         lsu_ready_o       <= ready_d;
         lsu_done_o        <= done_d;
         lsu_rdata_valid_o <= rvalid_d;
         lsu_err_o         <= err_d;
         lsu_rdata_o       <= rdata_d;
         data_req_o        <= req_d;
         data_we_o         <= we_d;
         data_be_o         <= be_d;
         data_addr_o       <= addr_d;
         data_wdata_o      <= wdata_d;
         if (state_d != state_q)
            tmo_cnt_q <= '0;
         else if (state_q != IDLE)
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
         if (accept) begin
            cap_type_q  <= lsu_type_i;
            cap_off_q   <= lsu_addr_i[1:0];
            cap_we_q    <= lsu_we_i;
            cap_sign_q  <= lsu_sign_ext_i;
`ifdef LSU_MISALIGNED_EN
            cap_be_hi_q <= be_full[7:4];
`endif
         end
`ifdef LSU_MISALIGNED_EN
         if (state_q == RVALID1 && data_rvalid_i) beat1_q <= data_rdata_i;
`endif
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_req, t_req, lsu_we, lsu_sign_ext;
   logic [1:0]  lsu_type;
   logic [31:0] lsu_addr, lsu_wdata;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;

   logic        lsu_ready_o, lsu_done_o, lsu_rdata_valid_o, lsu_err_o;
   logic [31:0] lsu_rdata_o;
   logic        data_req_o, data_we_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic [3:0]  data_be_o;

   logic        t_ready, t_done, t_rvalid, t_err, t_data_req, t_data_we;
   logic [31:0] t_rdata, t_data_addr, t_data_wdata;
   logic [3:0]  t_data_be;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [31:0] last_load = 32'h0;

   always #5 clk = ~clk;

   load_store_unit dut (
      .clk_i(clk), .rst_i(rst),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
      .lsu_sign_ext_i(lsu_sign_ext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_ready_o(lsu_ready_o), .lsu_done_o(lsu_done_o),
      .lsu_rdata_valid_o(lsu_rdata_valid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
      .data_err_i(data_err), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata)
   );

   load_store_unit #(.TIMEOUT_CYCLES(4)) dut_tmo (
      .clk_i(clk), .rst_i(rst),
      .lsu_req_i(t_req), .lsu_we_i(lsu_we), .lsu_type_i(lsu_type),
      .lsu_sign_ext_i(lsu_sign_ext), .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
      .lsu_ready_o(t_ready), .lsu_done_o(t_done),
      .lsu_rdata_valid_o(t_rvalid), .lsu_rdata_o(t_rdata), .lsu_err_o(t_err),
      .data_req_o(t_data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
      .data_err_i(data_err), .data_addr_o(t_data_addr), .data_we_o(t_data_we),
      .data_be_o(t_data_be), .data_wdata_o(t_data_wdata), .data_rdata_i(data_rdata)
   );

   typedef struct {
      logic        we;
      logic [1:0]  typ;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] resp;
      int          gnt_wait;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_rdata;
   } vec_t;

   localparam int NV = 12;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic issue(input logic we, input logic [1:0] typ, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      lsu_req = 1'b1; lsu_we = we; lsu_type = typ; lsu_sign_ext = sgn;
      lsu_addr = addr; lsu_wdata = wdata;
      @(negedge clk);
      lsu_req = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic stable;
      issue(v.we, v.typ, v.sgn, v.addr, v.wdata);
      chk($sformatf("v%0d_ready_low", idx), lsu_ready_o, 0);
      chk($sformatf("v%0d_req", idx), data_req_o, 1);
      chk($sformatf("v%0d_addr", idx), data_addr_o, v.exp_addr);
      chk($sformatf("v%0d_be", idx), data_be_o, v.exp_be);
      chk($sformatf("v%0d_we", idx), data_we_o, v.we);
      if (v.we) chk($sformatf("v%0d_wdata", idx), data_wdata_o, v.exp_wdata);
      stable = 1'b1;
      for (int i = 0; i < v.gnt_wait; i++) begin
         @(negedge clk);
         if (data_req_o !== 1'b1 || data_addr_o !== v.exp_addr || data_be_o !== v.exp_be)
            stable = 1'b0;
      end
      if (v.gnt_wait > 0) chk($sformatf("v%0d_stable", idx), stable, 1);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0;
      chk($sformatf("v%0d_req_drop", idx), data_req_o, 0);
      data_rvalid = 1'b1; data_rdata = v.resp;
      @(negedge clk);
      data_rvalid = 1'b0;
      chk($sformatf("v%0d_done", idx), lsu_done_o, 1);
      chk($sformatf("v%0d_err", idx), lsu_err_o, 0);
      chk($sformatf("v%0d_ready", idx), lsu_ready_o, 1);
      chk($sformatf("v%0d_rvalid", idx), lsu_rdata_valid_o, !v.we);
      if (!v.we) last_load = v.exp_rdata;
      chk($sformatf("v%0d_rdata", idx), lsu_rdata_o, last_load);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", idx), lsu_done_o, 0);
   endtask

`ifdef LSU_MISALIGNED_EN
   task automatic split_op(input string nm, input logic we, input logic [1:0] typ, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] a1, input logic [3:0] b1,
                           input logic [31:0] a2, input logic [3:0] b2,
                           input logic [31:0] wexp, input logic [31:0] rexp);
      issue(we, typ, sgn, addr, wdata);
      chk({nm, "_req1"}, data_req_o, 1);
      chk({nm, "_addr1"}, data_addr_o, a1);
      chk({nm, "_be1"}, data_be_o, b1);
      if (we) chk({nm, "_wdata1"}, data_wdata_o, wexp);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = r1;
      @(negedge clk);
      data_rvalid = 1'b0;
      chk({nm, "_req2"}, data_req_o, 1);
      chk({nm, "_addr2"}, data_addr_o, a2);
      chk({nm, "_be2"}, data_be_o, b2);
      chk({nm, "_no_early_done"}, lsu_done_o, 0);
      if (we) chk({nm, "_wdata2"}, data_wdata_o, wexp);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; data_rvalid = 1'b1; data_rdata = r2;
      @(negedge clk);
      data_rvalid = 1'b0;
      chk({nm, "_done"}, lsu_done_o, 1);
      chk({nm, "_err"}, lsu_err_o, 0);
      chk({nm, "_rvalid"}, lsu_rdata_valid_o, !we);
      if (!we) last_load = rexp;
      chk({nm, "_rdata"}, lsu_rdata_o, last_load);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //           we    typ    sgn   addr          wdata         resp          gw exp_addr      be     exp_wdata     exp_rdata
      vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h00000100, 32'h0,        32'hDEADBEEF, 0, 32'h00000100, 4'hF, 32'h0,        32'hDEADBEEF};
      vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h00000203, 32'h000000A5, 32'h0,        0, 32'h00000200, 4'h8, 32'hA5000000, 32'h0};
      vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h00000203, 32'h0,        32'hA5123456, 0, 32'h00000200, 4'h8, 32'h0,        32'h000000A5};
      vecs[3]  = '{1'b0, 2'b10, 1'b1, 32'h00000203, 32'h0,        32'hA5123456, 0, 32'h00000200, 4'h8, 32'h0,        32'hFFFFFFA5};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h00000102, 32'h0,        32'h80011234, 5, 32'h00000100, 4'hC, 32'h0,        32'hFFFF8001};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h00000102, 32'h0,        32'h80011234, 0, 32'h00000100, 4'hC, 32'h0,        32'h00008001};
      vecs[6]  = '{1'b1, 2'b01, 1'b0, 32'h00000101, 32'h0000BEEF, 32'h0,        2, 32'h00000100, 4'h6, 32'h00BEEF00, 32'h0};
      vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h00000300, 32'h12345678, 32'h0,        0, 32'h00000300, 4'hF, 32'h12345678, 32'h0};
      vecs[8]  = '{1'b0, 2'b11, 1'b1, 32'h00000104, 32'h0,        32'hCAFEF00D, 0, 32'h00000104, 4'hF, 32'h0,        32'hCAFEF00D};
      vecs[9]  = '{1'b0, 2'b10, 1'b1, 32'h00000001, 32'h0,        32'h00008000, 0, 32'h00000000, 4'h2, 32'h0,        32'hFFFFFF80};
      vecs[10] = '{1'b0, 2'b00, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0BADF00D, 1, 32'hFFFFFFFC, 4'hF, 32'h0,        32'h0BADF00D};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h00000000, 32'h0,        32'h123456FF, 0, 32'h00000000, 4'h1, 32'h0,        32'h000000FF};

      rst = 1'b1; lsu_req = 1'b0; t_req = 1'b0; lsu_we = 1'b0; lsu_type = 2'b00;
      lsu_sign_ext = 1'b0; lsu_addr = '0; lsu_wdata = '0;
      data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", lsu_ready_o, 1);
      chk("rst_req", data_req_o, 0);
      chk("rst_we", data_we_o, 0);
      chk("rst_done", lsu_done_o, 0);
      chk("rst_err", lsu_err_o, 0);
      chk("rst_rvalid", lsu_rdata_valid_o, 0);
      chk("rst_be", data_be_o, 0);
      chk("rst_addr", data_addr_o, 0);
      chk("rst_wdata", data_wdata_o, 0);
      chk("rst_rdata", lsu_rdata_o, 0);
      rst = 1'b0;

      for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

      // Bus error on an aligned load: error pulse, no rdata_valid, rdata holds
      issue(1'b0, 2'b00, 1'b0, 32'h00000100, 32'h0);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; data_rvalid = 1'b1; data_err = 1'b1; data_rdata = 32'h55555555;
      @(negedge clk);
      data_rvalid = 1'b0; data_err = 1'b0;
      chk("berr_done", lsu_done_o, 1);
      chk("berr_err", lsu_err_o, 1);
      chk("berr_rvalid", lsu_rdata_valid_o, 0);
      chk("berr_rdata_hold", lsu_rdata_o, last_load);

`ifdef LSU_MISALIGNED_EN
      split_op("lw1fe", 1'b0, 2'b00, 1'b0, 32'h000001FE, 32'h0, 32'h3344ABCD, 32'hABCD1122,
               32'h000001FC, 4'hC, 32'h00000200, 4'h3, 32'h0, 32'h11223344);
      split_op("sw1fe", 1'b1, 2'b00, 1'b0, 32'h000001FE, 32'h11223344, 32'h0, 32'h0,
               32'h000001FC, 4'hC, 32'h00000200, 4'h3, 32'h33441122, 32'h0);
      split_op("lh103", 1'b0, 2'b01, 1'b1, 32'h00000103, 32'h0, 32'hEE000000, 32'h000000FF,
               32'h00000100, 4'h8, 32'h00000104, 4'h1, 32'h0, 32'hFFFFFFEE);
      split_op("lwwrap", 1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h44000000, 32'h00112233,
               32'hFFFFFFFC, 4'h8, 32'h00000000, 4'h7, 32'h0, 32'h11223344);
      // Error on beat 1 of a split: terminate without a second beat
      issue(1'b0, 2'b00, 1'b0, 32'h000001FE, 32'h0);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; data_rvalid = 1'b1; data_err = 1'b1;
      @(negedge clk);
      data_rvalid = 1'b0; data_err = 1'b0;
      chk("serr_done", lsu_done_o, 1);
      chk("serr_err", lsu_err_o, 1);
      chk("serr_no_beat2", data_req_o, 0);
      @(negedge clk);
      chk("serr_still_idle", data_req_o, 0);
`else
      // Misaligned word and halfword are rejected with no bus activity
      issue(1'b0, 2'b00, 1'b0, 32'h000001FE, 32'h0);
      chk("mis_w_done", lsu_done_o, 1);
      chk("mis_w_err", lsu_err_o, 1);
      chk("mis_w_req", data_req_o, 0);
      chk("mis_w_ready", lsu_ready_o, 1);
      @(negedge clk);
      chk("mis_w_pulse", lsu_done_o, 0);
      chk("mis_w_req2", data_req_o, 0);
      issue(1'b0, 2'b01, 1'b0, 32'h00000103, 32'h0);
      chk("mis_h_done", lsu_done_o, 1);
      chk("mis_h_err", lsu_err_o, 1);
      chk("mis_h_req", data_req_o, 0);
`endif

      // Timeout instance: grant never arrives
      @(negedge clk);
      t_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'b00; lsu_addr = 32'h00000100;
      @(negedge clk);
      t_req = 1'b0;
      begin
         int req_cycles;
         bit seen;
         req_cycles = 0;
         seen = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            if (t_done) seen = 1'b1;
            else begin
               if (t_data_req) req_cycles++;
               @(negedge clk);
            end
         end
         chk("tmo_seen", seen, 1);
         chk("tmo_err", t_err, 1);
         chk("tmo_req_dropped", t_data_req, 0);
         chk("tmo_wait_len", (req_cycles >= 4 && req_cycles <= 5), 1);
      end
      data_rvalid = 1'b1; data_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      data_rvalid = 1'b0;
      begin
         bit quiet;
         quiet = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (t_done !== 1'b0 || t_rvalid !== 1'b0 || t_ready !== 1'b1) quiet = 1'b0;
         end
         chk("tmo_stray_ignored", quiet, 1);
      end

      // Reset while waiting for rvalid
      issue(1'b0, 2'b00, 1'b0, 32'h00000100, 32'h0);
      data_gnt = 1'b1;
      @(negedge clk);
      data_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_ready", lsu_ready_o, 1);
      chk("mrst_done", lsu_done_o, 0);
      chk("mrst_err", lsu_err_o, 0);
      chk("mrst_req", data_req_o, 0);
      chk("mrst_addr", data_addr_o, 0);
      chk("mrst_rdata", lsu_rdata_o, 0);
      last_load = 32'h0;
      run_vec(100, vecs[0]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
